// File: rtl/timebase_pkg.sv
// Shared constants and elaboration-time helpers for the timebase ticker.
// Mode encodings match the per-channel `mode` input bits.
package timebase_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // True when the clock divides evenly into base ticks of at least two cycles.
  function automatic bit div_ok(input int unsigned clk_hz, input int unsigned tick_hz);
    if (tick_hz == 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    return (clk_hz / tick_hz) >= 2;
  endfunction

  // Clamped to 2 on bad parameters so widths stay legal while the check reports.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    if (!div_ok(clk_hz, tick_hz)) return 2;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timebase_ticker_if.sv
// Control and pulse bundle between a timebase_ticker and its user.
// The user side is master (drives configuration), the ticker is slave.
interface timebase_ticker_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8
);

  logic              en;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    mode;
  logic [NCH-1:0]    start;
  logic [NCH*CW-1:0] period;
  logic              base_tick;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    busy;

  modport master (
    output en, ch_en, mode, start, period,
    input  base_tick, tick, busy
  );

  modport slave (
    input  en, ch_en, mode, start, period,
    output base_tick, tick, busy
  );

endinterface

// File: rtl/timebase_prescaler.sv
// Shared prescaler: emits a one-cycle base_tick every DIV enabled clk cycles.
// Disabling freezes the phase so it resumes exactly where it stopped.
module timebase_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic base_tick
);

  localparam int unsigned   PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre       <= '0;
      base_tick <= 1'b0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre       <= '0;
        base_tick <= 1'b1;
      end else begin
        pre       <= pre + PW'(1);
        base_tick <= 1'b0;
      end
    end else begin
      base_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timebase_ticker.sv
// Multi-channel timebase: one shared prescaler feeding NCH base-tick counters,
// each periodic or one-shot, producing single-cycle enable pulses on clk.
module timebase_ticker
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 8
) (
  input logic              clk,
  input logic              rst,
  timebase_ticker_if.slave bus
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

  if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_div_check
    $error("timebase_ticker: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic base_tick;

  timebase_prescaler #(.DIV(DIV)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .base_tick (base_tick)
  );

  assign bus.base_tick = base_tick;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] per;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          tick_q, tick_d;

    // Period is read live; a shrink below the current count wraps on the next tick.
    assign per = bus.period[i*CW +: CW];

    // NOTE: every variable gets its default first so no latch is inferred on untaken branches.
    always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      tick_d = 1'b0;
      if (!bus.ch_en[i]) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else if (bus.start[i]) begin
        cnt_d  = '0;
        busy_d = bus.mode[i];
      end else if (per == '0) begin
        cnt_d = '0;
      end else if (bus.mode[i] == MODE_ONESHOT && !busy_q) begin
        cnt_d = cnt_q;
      end else if (base_tick) begin
        if (cnt_q >= per - CW'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (bus.mode[i] == MODE_ONESHOT) busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A channel switched to periodic never reports itself armed.
      if (bus.mode[i] == MODE_PERIODIC) busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        busy_q <= busy_d;
        tick_q <= tick_d;
      end
    end

    assign bus.tick[i] = tick_q;
    assign bus.busy[i] = busy_q;
  end

endmodule

// File: tb/tb_timebase_ticker.sv
// Scoreboard bench for timebase_ticker with DIV=4, NCH=2, CW=4: stimulus queues
// expected pulse/edge events by cycle, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_timebase_ticker;

  localparam int NCH = 2;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timebase_ticker_if #(.NCH(NCH), .CW(CW)) bus ();

  timebase_ticker #(.CLK_HZ(4), .TICK_HZ(1), .NCH(NCH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Event kinds: 0 base_tick, 1+i tick[i], 1+NCH+i busy rise[i], 1+2*NCH+i busy fall[i].
  localparam int K_BASE = 0;
  localparam int K_TICK = 1;
  localparam int K_RISE = 1 + NCH;
  localparam int K_FALL = 1 + 2 * NCH;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  // cyc at a negedge equals k after the k-th edge with rst sampled low.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic string kind_name(input int k);
    if (k == K_BASE) return "base_tick";
    if (k < K_RISE)  return $sformatf("tick[%0d]", k - K_TICK);
    if (k < K_FALL)  return $sformatf("busy_rise[%0d]", k - K_RISE);
    return $sformatf("busy_fall[%0d]", k - K_FALL);
  endfunction

  task automatic expect_ev(input int c, input int k);
    ev_t e;
    int  idx = exp_q.size();
    e.cyc  = c;
    e.kind = k;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].cyc * 64 + exp_q[j].kind > c * 64 + k) begin
        idx = j;
        break;
      end
    end
    exp_q.insert(idx, e);
  endtask

  task automatic observe(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cyc %0d, required no event", kind_name(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != k) begin
        errors++;
        $display("FAIL event_order: got %s at cyc %0d, required %s at cyc %0d",
                 kind_name(k), cyc, kind_name(e.kind), e.cyc);
      end
    end
  endtask

  logic [NCH-1:0] busy_prev = '0;

  always @(negedge clk) begin
    if (bus.base_tick === 1'b1) observe(K_BASE);
    for (int i = 0; i < NCH; i++) if (bus.tick[i] === 1'b1) observe(K_TICK + i);
    for (int i = 0; i < NCH; i++)
      if (bus.busy[i] === 1'b1 && busy_prev[i] === 1'b0) observe(K_RISE + i);
    for (int i = 0; i < NCH; i++)
      if (bus.busy[i] === 1'b0 && busy_prev[i] === 1'b1) observe(K_FALL + i);
    busy_prev = bus.busy;
  end

  task automatic wait_cyc(input int k);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != k && guard < 1000);
    #1;
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: got cyc %0d, required %0d", cyc, k);
    end
  endtask

  task automatic scenario_done(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d events pending (first %s at cyc %0d), required 0",
               name, exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].cyc);
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic e, input logic [NCH-1:0] che, input logic [NCH-1:0] md,
                         input int p0, input int p1);
    bus.en     = e;
    bus.ch_en  = che;
    bus.mode   = md;
    bus.start  = '0;
    bus.period = {CW'(p1), CW'(p0)};
  endtask

  task automatic expect_base(input int first, input int last);
    for (int c = first; c <= last; c += 4) expect_ev(c, K_BASE);
  endtask

  initial begin
    set_cfg(1'b1, 2'b00, 2'b00, 0, 0);

    // Periodic period 10 on ch0, ch1 disabled.
    set_cfg(1'b1, 2'b01, 2'b00, 10, 3);
    do_reset();
    expect_base(4, 84);
    expect_ev(41, K_TICK + 0);
    expect_ev(81, K_TICK + 0);
    wait_cyc(86);
    scenario_done("periodic10");

    // One-shot period 3, then re-arm and restart mid-count.
    set_cfg(1'b1, 2'b01, 2'b01, 3, 0);
    do_reset();
    expect_base(4, 48);
    expect_ev(2,  K_RISE + 0);
    expect_ev(13, K_TICK + 0);
    expect_ev(13, K_FALL + 0);
    expect_ev(20, K_RISE + 0);
    expect_ev(37, K_TICK + 0);
    expect_ev(37, K_FALL + 0);
    wait_cyc(1);  bus.start = 2'b01;
    wait_cyc(2);  bus.start = 2'b00;
    wait_cyc(19); bus.start = 2'b01;
    wait_cyc(20); bus.start = 2'b00;
    wait_cyc(25); bus.start = 2'b01;
    wait_cyc(26); bus.start = 2'b00;
    wait_cyc(50);
    scenario_done("oneshot3");

    // Period 0 is inert; period 1 ticks after every base tick.
    set_cfg(1'b1, 2'b11, 2'b00, 0, 1);
    do_reset();
    expect_base(4, 28);
    for (int c = 5; c <= 29; c += 4) expect_ev(c, K_TICK + 1);
    wait_cyc(30);
    scenario_done("period0_1");

    // Shrink period 10 -> 5 with cnt at 7: wraps on the next base tick.
    set_cfg(1'b1, 2'b01, 2'b00, 10, 0);
    do_reset();
    expect_base(4, 80);
    expect_ev(33, K_TICK + 0);
    expect_ev(53, K_TICK + 0);
    expect_ev(73, K_TICK + 0);
    wait_cyc(30);
    bus.period = {CW'(0), CW'(5)};
    wait_cyc(82);
    scenario_done("shrink");

    // Start coincident with a base tick drops that tick.
    set_cfg(1'b1, 2'b01, 2'b00, 3, 0);
    do_reset();
    expect_base(4, 24);
    expect_ev(21, K_TICK + 0);
    wait_cyc(8); bus.start = 2'b01;
    wait_cyc(9); bus.start = 2'b00;
    wait_cyc(27);
    scenario_done("start_coincident");

    // Reset mid-count: pending tick lost, timing restarts from edge 1.
    do_reset();
    expect_base(4, 28);
    expect_ev(13, K_TICK + 0);
    expect_ev(25, K_TICK + 0);
    wait_cyc(30);
    scenario_done("reset_restart");

    // Global enable low for 7 edges shifts the phase by exactly 7 cycles.
    set_cfg(1'b1, 2'b01, 2'b00, 2, 0);
    do_reset();
    expect_ev(4, K_BASE);
    expect_ev(8, K_BASE);
    for (int c = 19; c <= 39; c += 4) expect_ev(c, K_BASE);
    expect_ev(9,  K_TICK + 0);
    expect_ev(24, K_TICK + 0);
    expect_ev(32, K_TICK + 0);
    expect_ev(40, K_TICK + 0);
    wait_cyc(9);  bus.en = 1'b0;
    wait_cyc(16); bus.en = 1'b1;
    wait_cyc(42);
    scenario_done("en_pause");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/timebase_ticker.md
# timebase_ticker

Parametrised multi-channel timebase generator for the 50 MHz board designs. A shared prescaler divides `clk` down to a base tick (1 Hz by default), and NCH independent channels count base ticks against a programmable period, each in periodic or one-shot mode. All outputs are single-`clk`-cycle enable pulses in the `clk` domain, never derived clocks, so downstream logic stays on one clock. It replaces the fixed per-period divider chain in the display, stopwatch and blinker designs.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency
- `TICK_HZ`, 1, base tick rate; DIV = CLK_HZ/TICK_HZ, must be integral and >= 2 (elaboration-time check)
- `NCH`, 4, number of channels
- `CW`, 8, period/count width per channel

- `clk`  in  1  system clock, one clock domain; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable; low freezes the prescaler
- `ch_en`  in  NCH  per-channel enable
- `mode`  in  NCH  per channel: 0 = periodic, 1 = one-shot
- `start`  in  NCH  one-cycle strobe: re-phase (periodic) or arm (one-shot)
- `period`  in  NCH*CW  packed; channel i at [i*CW +: CW], in base ticks
- `base_tick`  out  1  one-cycle pulse at TICK_HZ
- `tick`  out  NCH  one-cycle pulse per channel period
- `busy`  out  NCH  one-shot armed and counting

## Operation
- Prescaler `pre` (width clog2(DIV)). Each edge with `en`=1: if `pre`==DIV-1, then `pre`<=0 and `base_tick`<=1; else `pre`+1 and `base_tick`<=0. With `en`=0: `pre` holds and `base_tick`<=0.
- Channel counter `cnt[i]` (CW bits). Priority per edge, highest first:
  - `ch_en[i]`=0: `cnt`<=0, `busy`<=0, `tick`<=0.
  - `start[i]`=1: `cnt`<=0, `busy`<=`mode[i]`, `tick`<=0. Any coincident `base_tick` is not counted.
  - `period[i]`==0: `cnt`<=0, `tick`<=0. Channel is inert.
  - one-shot with `busy`=0: hold, `tick`<=0.
  - `base_tick`=1: if `cnt` >= `period`-1, then `cnt`<=0, `tick`<=1, and for one-shot `busy`<=0; else `cnt`+1.
  - otherwise: hold, `tick`<=0.
- Compare is >=, so shrinking `period` mid-count wraps on the next base tick. It never runs to 2^CW.
- `period` is sampled live at each base tick. No shadow register.
- `busy` is always 0 in periodic mode. Switching `mode` while counting takes effect at the next edge.

## Timing
- Reset values: `pre`=0, `cnt`=0, and `base_tick`, `tick`, `busy` all 0, on the edge after `rst` is sampled high. Reset mid-count aborts everything, and a pending tick is lost.
- Edge k is the k-th rising edge after `rst` is sampled low, with `en` held at 1. `base_tick` is high after edge DIV, 2·DIV, and so on, for exactly one cycle.
- Channel latency: `tick` rises one cycle after the `base_tick` it counts.
- Periodic period P >= 1: the first `tick` follows edge P·DIV+1, then repeats every P·DIV cycles.
- One-shot: `busy` rises one cycle after `start`. After P base ticks, `tick`=1 and `busy`=0 on the same edge.
- `start` while `busy` restarts the count from 0.

## Structure
- Package `timebase_pkg`: mode constants `MODE_PERIODIC`=0 and `MODE_ONESHOT`=1, plus the `DIV` computation and its check as a function.
- Sub-module `timebase_prescaler` holds the prescaler (`clk`, `rst`, `en` → `base_tick`). Channels sit in a generate loop in the top level.

## Test plan
All scenarios use CLK_HZ=4, TICK_HZ=1 (DIV=4), NCH=2, CW=4.
- Reset, `en`=1, ch0 periodic with `period`=10 → `base_tick` after edges 4, 8, …; `tick[0]` after edges 41, 81, …; ch1 (`ch_en`=0) stays 0.
- ch0 one-shot with `period`=3, `start` at edge 2 → `busy` high from edge 2 through edge 13; a single `tick` after edge 13 (the third base tick, at edge 12, plus one); no further ticks.
- `period`=0 → `tick` never asserts. `period`=1 → `tick` one cycle after every `base_tick`.
- Periodic `period`=10 reaches `cnt`=7, then `period` is changed to 5 → `tick` on the next base tick, and `cnt` returns to 0.
- `start` coincident with `base_tick` → that tick is not counted; `cnt`=0. Then `rst` mid-count → all outputs and counters 0 on the next edge, with timing restarting per the rules above.
- `en`=0 for 7 cycles mid-run → `base_tick` and `tick` both suppressed; the phase resumes shifted by exactly 7 cycles.
